// File: rtl/regfile_pkg.sv
// Shared defaults for the multi-port register file: geometry, PC step and
// CPSR flag bit positions.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 16;
  localparam int DEF_N_RD   = 4;
  localparam int DEF_N_WR   = 2;

  localparam int PC_STEP = 4;

  localparam int CPSR_N = 31;
  localparam int CPSR_Z = 30;
  localparam int CPSR_C = 29;
  localparam int CPSR_V = 28;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits: issue reserves a destination, any write to it
// clears the bit, and a same-cycle reserve beats the clear.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int DEPTH = DEF_DEPTH,
  parameter  int N_WR  = DEF_N_WR,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rsv_en,
  input  logic [AW-1:0]     rsv_addr,
  input  logic [N_WR-1:0]   wr_en,
  input  logic [N_WR*AW-1:0] wr_addr,
  output logic              rsv_ok,
  output logic [DEPTH-1:0]  pend,
  output logic [DEPTH-1:0]  pend_next
);

  logic [DEPTH-1:0] pend_q;
  logic [DEPTH-1:0] pend_d;

  // Only current pend feeds rsv_ok, so there is no path from the write ports.
  assign rsv_ok = rsv_en & ~pend_q[rsv_addr];

  always_comb begin
    pend_d = pend_q;
    for (int w = 0; w < N_WR; w++) begin
      if (wr_en[w]) begin
        pend_d[wr_addr[w*AW +: AW]] = 1'b0;
      end
    end
    if (rsv_ok) begin
      pend_d[rsv_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign pend      = pend_q;
  assign pend_next = pend_d;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with PC/CPSR special registers,
// priority write muxing, write-through registered reads and a scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int DEPTH  = DEF_DEPTH,
  parameter  int N_RD   = DEF_N_RD,
  parameter  int N_WR   = DEF_N_WR,
  parameter  int PC_IDX = DEPTH - 1,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_RD*AW-1:0]     rd_addr,
  output logic [N_RD*DATA_W-1:0] rd_data,
  output logic [N_RD-1:0]        rd_ready,
  input  logic [N_WR-1:0]        wr_en,
  input  logic [N_WR*AW-1:0]     wr_addr,
  input  logic [N_WR*DATA_W-1:0] wr_data,
  input  logic                   rsv_en,
  input  logic [AW-1:0]          rsv_addr,
  output logic                   rsv_ok,
  input  logic                   pc_write,
  input  logic [DATA_W-1:0]      pc_update,
  input  logic                   pc_inc,
  output logic [DATA_W-1:0]      pc,
  input  logic                   cpsr_write,
  input  logic [DATA_W-1:0]      cpsr_mask,
  input  logic [DATA_W-1:0]      cpsr_update,
  output logic [DATA_W-1:0]      cpsr,
  output logic [DEPTH-1:0]       pend
);

  localparam logic [AW-1:0] PC_A = AW'(PC_IDX);

  logic [DATA_W-1:0]      regs_q [DEPTH];
  logic [DATA_W-1:0]      regs_d [DEPTH];
  logic [DATA_W-1:0]      cpsr_q, cpsr_d;
  logic [N_RD*DATA_W-1:0] rd_data_q, rd_data_d;
  logic [N_RD-1:0]        rd_ready_q, rd_ready_d;
  logic [DEPTH-1:0]       pend_next;

  regfile_scoreboard #(
    .DEPTH (DEPTH),
    .N_WR  (N_WR)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .rsv_en    (rsv_en),
    .rsv_addr  (rsv_addr),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .rsv_ok    (rsv_ok),
    .pend      (pend),
    .pend_next (pend_next)
  );

  // Later assignments win: pc_inc < pc_write < write port 0 < ... < port N_WR-1.
  always_comb begin
    regs_d = regs_q;
    if (pc_inc) begin
      regs_d[PC_A] = regs_q[PC_A] + DATA_W'(PC_STEP);
    end
    if (pc_write) begin
      regs_d[PC_A] = pc_update;
    end
    for (int w = 0; w < N_WR; w++) begin
      if (wr_en[w]) begin
        regs_d[wr_addr[w*AW +: AW]] = wr_data[w*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    cpsr_d = cpsr_q;
    if (cpsr_write) begin
      cpsr_d = (cpsr_q & ~cpsr_mask) | (cpsr_update & cpsr_mask);
    end
  end

  // Reads sample next-state values so same-edge writes are bypassed.
  always_comb begin
    rd_data_d  = '0;
    rd_ready_d = '0;
    for (int i = 0; i < N_RD; i++) begin
      rd_data_d[i*DATA_W +: DATA_W] = regs_d[rd_addr[i*AW +: AW]];
      rd_ready_d[i]                 = ~pend_next[rd_addr[i*AW +: AW]];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q     <= '{default: '0};
      cpsr_q     <= '0;
      rd_data_q  <= '0;
      rd_ready_q <= '1;
    end else begin
      regs_q     <= regs_d;
      cpsr_q     <= cpsr_d;
      rd_data_q  <= rd_data_d;
      rd_ready_q <= rd_ready_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_ready = rd_ready_q;
  assign pc       = regs_q[PC_A];
  assign cpsr     = cpsr_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: reset, write priority, PC/CPSR updates,
// scoreboard behaviour and asynchronous reset, all with hand-computed values.
module tb_regfile_mp;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int N_RD   = 4;
  localparam int N_WR   = 2;
  localparam int AW     = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N_RD*AW-1:0]     rd_addr;
  logic [N_RD*DATA_W-1:0] rd_data;
  logic [N_RD-1:0]        rd_ready;
  logic [N_WR-1:0]        wr_en;
  logic [N_WR*AW-1:0]     wr_addr;
  logic [N_WR*DATA_W-1:0] wr_data;
  logic                   rsv_en;
  logic [AW-1:0]          rsv_addr;
  logic                   rsv_ok;
  logic                   pc_write;
  logic [DATA_W-1:0]      pc_update;
  logic                   pc_inc;
  logic [DATA_W-1:0]      pc;
  logic                   cpsr_write;
  logic [DATA_W-1:0]      cpsr_mask;
  logic [DATA_W-1:0]      cpsr_update;
  logic [DATA_W-1:0]      cpsr;
  logic [DEPTH-1:0]       pend;

  int vectors    = 0;
  int miscompares = 0;

  regfile_mp dut (
    .clk         (clk),
    .rst         (rst),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_ready    (rd_ready),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rsv_en      (rsv_en),
    .rsv_addr    (rsv_addr),
    .rsv_ok      (rsv_ok),
    .pc_write    (pc_write),
    .pc_update   (pc_update),
    .pc_inc      (pc_inc),
    .pc          (pc),
    .cpsr_write  (cpsr_write),
    .cpsr_mask   (cpsr_mask),
    .cpsr_update (cpsr_update),
    .cpsr        (cpsr),
    .pend        (pend)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idleInputs();
    wr_en       = '0;
    wr_addr     = '0;
    wr_data     = '0;
    rsv_en      = 1'b0;
    rsv_addr    = '0;
    pc_write    = 1'b0;
    pc_update   = '0;
    pc_inc      = 1'b0;
    cpsr_write  = 1'b0;
    cpsr_mask   = '0;
    cpsr_update = '0;
  endtask

  // One rising edge, then settle 1 time unit so outputs are sampled away from it.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  initial begin
    $display("[TB] regfile_mp directed test start");

    // Reset with busy inputs
    rst         = 1'b1;
    rd_addr     = {4'd5, 4'd15, 4'd3, 4'd3};
    wr_en       = 2'b11;
    wr_addr     = {4'd5, 4'd15};
    wr_data     = {32'hDEADBEEF, 32'h12345678};
    rsv_en      = 1'b1;
    rsv_addr    = 4'd5;
    pc_write    = 1'b1;
    pc_update   = 32'h0000_0400;
    pc_inc      = 1'b1;
    cpsr_write  = 1'b1;
    cpsr_mask   = 32'hFFFF_FFFF;
    cpsr_update = 32'hFFFF_FFFF;
    applyStimulus();
    applyStimulus();
    checkOutput("rst_pend", {16'h0, pend}, 32'h0);
    checkOutput("rst_pc", pc, 32'h0);
    checkOutput("rst_cpsr", cpsr, 32'h0);
    checkOutput("rst_rdata0", rd_data[31:0], 32'h0);
    checkOutput("rst_rready", {28'h0, rd_ready}, 32'hF);

    idleInputs();
    rst = 1'b0;
    applyStimulus();
    checkOutput("post_rst_rdata", rd_data[31:0], 32'h0);
    checkOutput("post_rst_rready", {28'h0, rd_ready}, 32'hF);
    checkOutput("post_rst_pc", pc, 32'h0);
    checkOutput("post_rst_pend", {16'h0, pend}, 32'h0);

    // Write collision on R3: port 1 wins, bypassed into rd_data0
    wr_en   = 2'b11;
    wr_addr = {4'd3, 4'd3};
    wr_data = {32'h22, 32'h11};
    rd_addr = {4'd0, 4'd0, 4'd0, 4'd3};
    applyStimulus();
    checkOutput("collide_bypass", rd_data[31:0], 32'h22);
    idleInputs();
    applyStimulus();
    checkOutput("collide_hold", rd_data[31:0], 32'h22);

    // PC priority
    pc_write  = 1'b1;
    pc_update = 32'h100;
    applyStimulus();
    checkOutput("pc_load", pc, 32'h100);
    idleInputs();
    pc_inc = 1'b1;
    applyStimulus();
    checkOutput("pc_inc", pc, 32'h104);
    pc_write  = 1'b1;
    pc_update = 32'h200;
    applyStimulus();
    checkOutput("pc_write_over_inc", pc, 32'h200);
    wr_en     = 2'b10;
    wr_addr   = {4'd15, 4'd0};
    wr_data   = {32'h300, 32'h0};
    rd_addr   = {4'd0, 4'd0, 4'd15, 4'd3};
    applyStimulus();
    checkOutput("wr_over_pc_write", pc, 32'h300);
    checkOutput("wr_over_pc_bypass", rd_data[63:32], 32'h300);
    idleInputs();
    pc_write  = 1'b1;
    pc_update = 32'hFFFF_FFFC;
    applyStimulus();
    idleInputs();
    pc_inc = 1'b1;
    applyStimulus();
    checkOutput("pc_wrap", pc, 32'h0);
    checkOutput("pc_wrap_bypass", rd_data[63:32], 32'h0);

    // Masked CPSR updates
    idleInputs();
    cpsr_write  = 1'b1;
    cpsr_mask   = 32'hF000_0000;
    cpsr_update = 32'hA000_0001;
    applyStimulus();
    checkOutput("cpsr_flags", cpsr, 32'hA000_0000);
    cpsr_mask   = 32'h0000_000F;
    cpsr_update = 32'hFFFF_FFF5;
    applyStimulus();
    checkOutput("cpsr_low", cpsr, 32'hA000_0005);
    idleInputs();
    applyStimulus();
    checkOutput("cpsr_hold", cpsr, 32'hA000_0005);

    // Scoreboard sequence on R5, read on port 2
    rd_addr  = {4'd0, 4'd5, 4'd15, 4'd3};
    rsv_en   = 1'b1;
    rsv_addr = 4'd5;
    #1;
    checkOutput("rsv_ok_first", {31'h0, rsv_ok}, 32'h1);
    applyStimulus();
    checkOutput("rsv_pend", {16'h0, pend}, 32'h0020);
    checkOutput("rsv_rready", {31'h0, rd_ready[2]}, 32'h0);
    #1;
    checkOutput("rsv_ok_again", {31'h0, rsv_ok}, 32'h0);
    applyStimulus();
    checkOutput("rsv_again_pend", {16'h0, pend}, 32'h0020);

    // Writing a non-pending register leaves pend alone
    idleInputs();
    wr_en   = 2'b01;
    wr_addr = {4'd0, 4'd6};
    wr_data = {32'h0, 32'h66};
    applyStimulus();
    checkOutput("nonpend_write", {16'h0, pend}, 32'h0020);

    wr_en   = 2'b01;
    wr_addr = {4'd0, 4'd5};
    wr_data = {32'h0, 32'h7};
    applyStimulus();
    checkOutput("wr_clear_pend", {16'h0, pend}, 32'h0);
    checkOutput("wr_clear_rready", {31'h0, rd_ready[2]}, 32'h1);
    checkOutput("wr_clear_rdata", rd_data[95:64], 32'h7);

    wr_en    = 2'b10;
    wr_addr  = {4'd5, 4'd0};
    wr_data  = {32'h9, 32'h0};
    rsv_en   = 1'b1;
    rsv_addr = 4'd5;
    #1;
    checkOutput("rsv_wr_ok", {31'h0, rsv_ok}, 32'h1);
    applyStimulus();
    checkOutput("rsv_wr_pend", {16'h0, pend}, 32'h0020);
    checkOutput("rsv_wr_rdata", rd_data[95:64], 32'h9);
    checkOutput("rsv_wr_rready", {31'h0, rd_ready[2]}, 32'h0);

    // Give PC a nonzero value, then reset between edges
    idleInputs();
    pc_write  = 1'b1;
    pc_update = 32'h40;
    applyStimulus();
    checkOutput("pre_async_pc", pc, 32'h40);
    idleInputs();
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_pend", {16'h0, pend}, 32'h0);
    checkOutput("async_cpsr", cpsr, 32'h0);
    checkOutput("async_pc", pc, 32'h0);
    checkOutput("async_rready", {28'h0, rd_ready}, 32'hF);
    checkOutput("async_rdata", rd_data[95:64], 32'h0);
    #1;
    rst = 1'b0;
    applyStimulus();
    checkOutput("after_async_r5", rd_data[95:64], 32'h0);
    checkOutput("after_async_pc", pc, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file with a register scoreboard, successor to the fixed 16×32 four-read/two-write register block. It keeps the general-purpose array and the PC and CPSR special registers, and adds:

- configurable width, depth and port counts;
- deterministic write priority;
- write-through (bypassed) registered reads;
- PC auto-increment and masked CPSR update;
- per-register pending bits, so issue logic can reserve a destination and see when the operand is ready.

It sits between decode/issue and the execute/writeback units.

## Interface
Parameters:
- DATA_W, 32, register width
- DEPTH, 16, number of registers, power of two ≥ 2; AW = $clog2(DEPTH)
- N_RD, 4, read ports
- N_WR, 2, write ports
- PC_IDX, DEPTH-1, index of the program-counter register

Ports. Clock and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- rd_addr  in  N_RD*AW  read addresses, port i in slice i
- rd_data  out  N_RD*DATA_W  registered read data
- rd_ready  out  N_RD  registered: addressed register not pending
- wr_en  in  N_WR  write enables
- wr_addr  in  N_WR*AW  write addresses
- wr_data  in  N_WR*DATA_W  write data
- rsv_en  in  1  reserve request for rsv_addr
- rsv_addr  in  AW  destination to mark pending
- rsv_ok  out  1  combinational: reservation accepted this cycle
- pc_write  in  1  load PC from pc_update
- pc_update  in  DATA_W  new PC value
- pc_inc  in  1  PC += 4
- pc  out  DATA_W  current R[PC_IDX]
- cpsr_write  in  1  masked CPSR update
- cpsr_mask  in  DATA_W  bit-enable for cpsr_update
- cpsr_update  in  DATA_W  new CPSR bits
- cpsr  out  DATA_W  current CPSR
- pend  out  DEPTH  current pending bit per register

## Operation
- Reset (async assert, applies immediately):
  - all R = 0, cpsr = 0, pend = 0;
  - rd_data = 0, rd_ready = all ones.
- Next-state of R[k] per edge, lowest to highest priority:
  - hold;
  - pc_inc (k = PC_IDX only, +4 modulo 2^DATA_W);
  - pc_write (k = PC_IDX);
  - wr port 0 … wr port N_WR-1.
  - Higher-index write port wins on an address collision.
  - General writes to PC_IDX override pc_write and pc_inc.
- CPSR next = (cpsr & ~cpsr_mask) | (cpsr_update & cpsr_mask) when cpsr_write; otherwise hold.
- Reads are write-through. rd_data[i] is loaded with the next-state value of R[rd_addr[i]], so a same-edge write is visible in the same cycle.
- Scoreboard:
  - rsv_ok = rsv_en & ~pend[rsv_addr].
  - An accepted reservation sets pend[rsv_addr].
  - Any wr_en to address k clears pend[k].
  - Reserve and write to the same address in one cycle: the set wins (new producer). The register still takes the written data.
  - Reserve of an already-pending register: rsv_ok = 0, no state change.
  - Writing a non-pending register is legal and leaves pend unchanged.
  - pc_write, pc_inc and cpsr_write never touch pend.
- rd_ready[i] is loaded with ~pend_next[rd_addr[i]].

## Timing
- Read latency is 1 cycle: the address is presented before edge n; rd_data and rd_ready are valid after edge n.
- Write latency: a write presented before edge n is visible on pc/cpsr/pend after edge n. rd_data reflects it at edge n via the bypass.
- rsv_ok is combinational from rsv_en, rsv_addr and current pend, with no path from wr_* inputs.
- rst deasserted mid-stream: the first edge after deassertion performs normal updates; no state survives an assertion.
- Address widths match DEPTH exactly; no out-of-range addresses exist.

## Structure
- Package regfile_pkg:
  - default DATA_W, DEPTH, N_RD, N_WR;
  - PC_STEP = 4;
  - CPSR flag positions N = 31, Z = 30, C = 29, V = 28.
- Sub-module regfile_scoreboard: pend vector, rsv_ok, set/clear priority, pend_next output.
- Top-level: data array, priority write muxing, PC/CPSR logic, bypassed read registers.

## Test plan
- Reset with data on all inputs, then release → rd_data = 0, rd_ready = 4'b1111, pc = 0, cpsr = 0, pend = 0.
- Write collision: wr_en = 2'b11, both ports to R3, port 0 data 0x11, port 1 data 0x22, rd_addr0 = 3 same cycle → after the edge, rd_data0 = 0x22 (bypassed, port 1 wins).
- PC priority:
  - pc_inc from 0x100 → pc = 0x104;
  - pc_write 0x200 with pc_inc → 0x200;
  - wr port to PC_IDX with 0x300 plus pc_write 0x200 → 0x300;
  - pc_inc at 0xFFFFFFFC → 0.
- CPSR: cpsr = 0, then mask 0xF0000000 with update 0xA0000001 → cpsr = 0xA0000000.
- Scoreboard sequence on R5:
  - reserve R5 → rsv_ok = 1, pend[5] = 1, rd_ready for R5 = 0;
  - re-reserve R5 → rsv_ok = 0;
  - write R5 = 7 → pend[5] = 0, rd_ready = 1, rd_data = 7;
  - reserve and write R5 in the same cycle → pend[5] = 1, R5 = written value.
- Async reset asserted between edges with pend ≠ 0 → pend, cpsr and pc clear immediately, without waiting for the clock.
